// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the arbiter's handshake and memory-bus signals.
//   Fetch port : i_req, i_addr (to arbiter); i_rdata, i_ready (from arbiter)
//   Data port  : d_req, d_we, d_addr, d_wdata (to arbiter); d_rdata, d_ready
//   Memory bus : m_en, m_we, m_addr, m_wdata (from arbiter); m_rdata (to arbiter)
//   Status     : busy (from arbiter)
// Modports:
//   slave  - the arbiter itself
//   master - the core plus memory surrounding the arbiter
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port, fixed-latency memory between an instruction-fetch
// port (I) and a data port (D). Each access runs IDLE -> ISSUE -> (WAIT) ->
// RESP. Data has priority, but after MAX_D_BURST consecutive D grants taken
// while a fetch was waiting, the fetch is granted next.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low reset (0 = reset)
//   bus   - mem_arbiter_if.slave: fetch/data handshakes, memory bus, busy
// Parameters:
//   MEM_LAT     - cycles from the m_en cycle to valid m_rdata (1..15)
//   MAX_D_BURST - max consecutive D grants while i_req is pending (1..15)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MEM_LAT     = 2,
  parameter int MAX_D_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  localparam logic [3:0] LAT_M1    = 4'(MEM_LAT - 1);
  localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

  state_t      state_reg, state_next;
  owner_t      owner_reg, owner_next;
  logic [3:0]  burst_reg, burst_next;
  logic [3:0]  wait_reg,  wait_next;
  logic [31:0] addr_reg,  addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        we_reg,    we_next;
  logic        force_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      owner_reg <= OWN_NONE;
      burst_reg <= 4'd0;
      wait_reg  <= 4'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      burst_reg <= burst_next;
      wait_reg  <= wait_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
    end
  end

  // A waiting fetch that has already watched MAX_D_BURST data grants go by
  // wins over data on this arbitration.
  assign force_i = bus.i_req && (burst_reg == BURST_MAX);

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    burst_next = burst_reg;
    wait_next  = wait_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    we_next    = we_reg;

    case (state_reg)
      IDLE: begin
        if (bus.d_req && !force_i) begin
          owner_next = OWN_D;
          addr_next  = bus.d_addr;
          wdata_next = bus.d_wdata;
          we_next    = bus.d_we;
          // Only count D grants that actually made a fetch wait.
          if (bus.i_req)
            burst_next = (burst_reg == 4'hF) ? burst_reg : burst_reg + 4'd1;
          else
            burst_next = 4'd0;
          state_next = ISSUE;
        end else if (bus.i_req) begin
          owner_next = OWN_I;
          addr_next  = bus.i_addr;
          wdata_next = 32'd0;
          we_next    = 1'b0;
          burst_next = 4'd0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (we_reg || (MEM_LAT == 1)) begin
          state_next = RESP;
        end else begin
          wait_next  = LAT_M1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        wait_next = wait_reg - 4'd1;
        if (wait_reg == 4'd1)
          state_next = RESP;
      end
      RESP: begin
        owner_next = OWN_NONE;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode the registered state; rdata is a pass-through of m_rdata
  // in the response cycle so the memory's data reaches the core with no
  // extra register stage.
  assign bus.m_en    = (state_reg == ISSUE);
  assign bus.m_we    = (state_reg == ISSUE) && we_reg;
  assign bus.m_addr  = addr_reg;
  assign bus.m_wdata = wdata_reg;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.i_ready = (state_reg == RESP) && (owner_reg == OWN_I);
  assign bus.d_ready = (state_reg == RESP) && (owner_reg == OWN_D);
  assign bus.i_rdata = (bus.i_ready && !we_reg) ? bus.m_rdata : 32'd0;
  assign bus.d_rdata = (bus.d_ready && !we_reg) ? bus.m_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Scoreboard bench for mem_arbiter. Instance A (MEM_LAT=2, MAX_D_BURST=4)
// carries the main sequence; instances B (MEM_LAT=1) and C (MEM_LAT=3) check
// read latency. Expected accesses are queued when requests are driven and
// popped when the DUT issues m_en and when it pulses ready.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LAT_A = 2;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          en_cyc;
    int          rdy_cyc;
    bit          resp;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t        exp_q[$];
  exp_t        resp_q[$];
  logic [31:0] i_q[$];
  dreq_t       d_q[$];

  mem_arbiter_if ifa();
  mem_arbiter_if ifb();
  mem_arbiter_if ifc();

  mem_arbiter #(.MEM_LAT(2), .MAX_D_BURST(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  mem_arbiter #(.MEM_LAT(1), .MAX_D_BURST(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  mem_arbiter #(.MEM_LAT(3), .MAX_D_BURST(4)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B9) ^ 32'h12345678;
  endfunction

  // Memory models: a read strobed in cycle t returns data in cycle t+LAT;
  // every other cycle shows a poison value.
  logic [32:0] la [0:1];
  logic [32:0] lb;
  logic [32:0] lc [0:2];
  always @(posedge clk) begin
    la[0] <= (ifa.m_en && !ifa.m_we) ? {1'b1, memf(ifa.m_addr)} : 33'd0;
    la[1] <= la[0];
    lb    <= (ifb.m_en && !ifb.m_we) ? {1'b1, memf(ifb.m_addr)} : 33'd0;
    lc[0] <= (ifc.m_en && !ifc.m_we) ? {1'b1, memf(ifc.m_addr)} : 33'd0;
    lc[1] <= lc[0];
    lc[2] <= lc[1];
  end
  assign ifa.m_rdata = la[1][32] ? la[1][31:0] : 32'hBAD0BAD0;
  assign ifb.m_rdata = lb[32]    ? lb[31:0]    : 32'hBAD0BAD0;
  assign ifc.m_rdata = lc[2][32] ? lc[2][31:0] : 32'hBAD0BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    ifa.i_req   = (i_q.size() != 0);
    ifa.i_addr  = (i_q.size() != 0) ? i_q[0] : 32'd0;
    ifa.d_req   = (d_q.size() != 0);
    ifa.d_we    = (d_q.size() != 0) ? d_q[0].we : 1'b0;
    ifa.d_addr  = (d_q.size() != 0) ? d_q[0].addr : 32'd0;
    ifa.d_wdata = (d_q.size() != 0) ? d_q[0].wdata : 32'd0;
  endtask

  // One cycle: score instance A's outputs, then let the requesters advance.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (!ifa.m_en) check("m_we_outside_issue", {31'd0, ifa.m_we}, 32'd0);
    if (ifa.m_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_m_en", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("en_cycle", 32'(cyc), 32'(e.en_cyc));
        check("m_addr", ifa.m_addr, e.addr);
        check("m_we", {31'd0, ifa.m_we}, {31'd0, e.we});
        check("m_wdata", ifa.m_wdata, e.wdata);
        if (e.resp) resp_q.push_back(e);
      end
    end
    if (ifa.i_ready || ifa.d_ready) begin
      if (resp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = resp_q.pop_front();
        $display("txn %s we=%0d addr=%h cycle=%0d", e.is_d ? "D" : "I", e.we, e.addr, cyc);
        check("i_ready", {31'd0, ifa.i_ready}, {31'd0, !e.is_d});
        check("d_ready", {31'd0, ifa.d_ready}, {31'd0, e.is_d});
        check("ready_cycle", 32'(cyc), 32'(e.rdy_cyc));
        check("owner_rdata", e.is_d ? ifa.d_rdata : ifa.i_rdata, e.rdata);
        check("other_rdata", e.is_d ? ifa.i_rdata : ifa.d_rdata, 32'd0);
        check("m_addr_stable", ifa.m_addr, e.addr);
      end
    end
    if (ifa.i_ready && i_q.size() != 0) void'(i_q.pop_front());
    if (ifa.d_ready && d_q.size() != 0) void'(d_q.pop_front());
    drive();
  endtask

  task automatic push_exp(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int t0, input bit resp);
    exp_t e;
    e.is_d    = is_d;
    e.we      = we;
    e.addr    = addr;
    e.wdata   = wdata;
    e.rdata   = we ? 32'd0 : memf(addr);
    e.en_cyc  = t0 + 1;
    e.rdy_cyc = we ? t0 + 2 : t0 + 1 + LAT_A;
    e.resp    = resp;
    exp_q.push_back(e);
  endtask

  task automatic push_i(input logic [31:0] addr, input int t0, input bit resp);
    i_q.push_back(addr);
    push_exp(1'b0, 1'b0, addr, 32'd0, t0, resp);
    drive();
  endtask

  task automatic push_d(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int t0);
    dreq_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    d_q.push_back(r);
    push_exp(1'b1, we, addr, wdata, t0, 1'b1);
    drive();
  endtask

  task automatic drain(input int max_cycles);
    for (int n = 0; n < max_cycles && (exp_q.size() != 0 || resp_q.size() != 0); n++) step();
    check("drain_timeout", 32'(exp_q.size() + resp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_en"},    {31'd0, ifa.m_en},    32'd0);
    check({tag, "_m_we"},    {31'd0, ifa.m_we},    32'd0);
    check({tag, "_m_addr"},  ifa.m_addr,           32'd0);
    check({tag, "_m_wdata"}, ifa.m_wdata,          32'd0);
    check({tag, "_i_ready"}, {31'd0, ifa.i_ready}, 32'd0);
    check({tag, "_d_ready"}, {31'd0, ifa.d_ready}, 32'd0);
    check({tag, "_i_rdata"}, ifa.i_rdata,          32'd0);
    check({tag, "_d_rdata"}, ifa.d_rdata,          32'd0);
    check({tag, "_busy"},    {31'd0, ifa.busy},    32'd0);
  endtask

  initial begin
    int t;
    int rb, rc, waitc;

    drive();
    ifb.i_req = 1'b0; ifb.i_addr = 32'd0; ifb.d_req = 1'b0; ifb.d_we = 1'b0;
    ifb.d_addr = 32'd0; ifb.d_wdata = 32'd0;
    ifc.i_req = 1'b0; ifc.i_addr = 32'd0; ifc.d_req = 1'b0; ifc.d_we = 1'b0;
    ifc.d_addr = 32'd0; ifc.d_wdata = 32'd0;

    // Reset state
    step(); step();
    check_idle_outputs("reset");
    reset = 1'b1;
    step();

    // Single fetch read of 0x40
    push_i(32'h40, cyc, 1'b1);
    drain(20);
    step();
    check("fetch_busy_after", {31'd0, ifa.busy}, 32'd0);

    // Data write
    push_d(1'b1, 32'h54, 32'h7, cyc);
    drain(20);
    step();

    // Simultaneous requests: D first, then I
    t = cyc;
    push_d(1'b0, 32'h80, 32'd0, t);
    push_i(32'h10, t + 4, 1'b1);
    drain(30);
    step();

    // Both held high: D,D,D,D,I,D,D,D,D,I
    t = cyc;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push_i(32'h1000 + 32'(k * 4), t, 1'b1);
      else                  push_d(1'b0, 32'h2000 + 32'(k * 4), 32'd0, t);
      t += 4;
    end
    drain(80);
    step();

    // Read latency for MEM_LAT=1 and MEM_LAT=3
    ifb.i_req = 1'b1; ifb.i_addr = 32'h44;
    ifc.i_req = 1'b1; ifc.i_addr = 32'h44;
    t = cyc; rb = -1; rc = -1; waitc = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (ifb.i_ready) begin
        if (rb < 0) rb = cyc - t;
        check("lat1_rdata", ifb.i_rdata, memf(32'h44));
        ifb.i_req = 1'b0;
      end
      if (ifc.i_ready) begin
        if (rc < 0) rc = cyc - t;
        check("lat3_rdata", ifc.i_rdata, memf(32'h44));
        ifc.i_req = 1'b0;
      end
      if (ifc.busy && !ifc.m_en && !ifc.i_ready) waitc++;
    end
    check("lat1_ready_cycle", 32'(rb), 32'd2);
    check("lat3_ready_cycle", 32'(rc), 32'd4);
    check("lat3_wait_cycles", 32'(waitc), 32'd2);

    // Reset during the WAIT of a read aborts it
    push_i(32'h200, cyc, 1'b0);
    step();
    step();
    reset = 1'b0;
    i_q.delete();
    drive();
    step();
    check_idle_outputs("abort");
    reset = 1'b1;
    step(); step(); step();

    // Service resumes normally after reset
    push_d(1'b0, 32'h300, 32'd0, cyc);
    drain(20);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port (I) and data-access port (D).
- Sequences each access through a fixed-latency memory: issue, wait, respond.
- Data has priority over fetch, with a bounded-burst fairness rule so fetch cannot starve.
- Sits between the mips core and the memory; the core stalls fetch and memory stages on the ready handshakes.

Parameters:
- MEM_LAT, 2: cycles from the m_en cycle to valid m_rdata; legal range 1..15.
- MAX_D_BURST, 4: maximum consecutive D grants while i_req is pending; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- i_req  input  1  fetch request; held with i_addr until i_ready
- i_addr  input  32  fetch byte address
- i_rdata  output  32  fetch data; valid only while i_ready=1
- i_ready  output  1  one-cycle pulse: fetch complete
- d_req  input  1  data request; held with d_we, d_addr and d_wdata until d_ready
- d_we  input  1  1 = write, 0 = read
- d_addr  input  32  data byte address
- d_wdata  input  32  write data
- d_rdata  output  32  read data; valid only while d_ready=1
- d_ready  output  1  one-cycle pulse: data access complete
- m_en  output  1  memory access strobe, one cycle per access
- m_we  output  1  memory write enable; qualifies m_en
- m_addr  output  32  memory address, registered
- m_wdata  output  32  memory write data, registered
- m_rdata  input  32  memory read data, valid MEM_LAT cycles after the m_en cycle
- busy  output  1  1 whenever the state is not IDLE

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE; owner=none; burst counter=0; wait counter=0.
  - All outputs are 0, including m_addr, m_wdata, i_rdata and d_rdata.
  - Reset mid-access aborts the access: no ready pulse is generated and late m_rdata is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled only in this state.
  - If d_req=1 and it is not a forced-I case, grant D.
  - Else if i_req=1, grant I.
  - Else remain in IDLE.
  - Forced-I case: i_req=1 and burst counter = MAX_D_BURST.
  - On a grant, latch the owner and register the address/we/wdata onto m_*, then go to ISSUE.
  - For an I grant, m_we=0 and m_wdata=0.
- ISSUE: m_en=1 for exactly this cycle.
  - A write goes to RESP.
  - A read with MEM_LAT=1 goes to RESP.
  - Otherwise go to WAIT and load the wait counter with MEM_LAT-1.
- WAIT: decrement the wait counter each cycle; go to RESP when it reaches 1. WAIT therefore lasts MEM_LAT-1 cycles.
- RESP: pulse the owner's ready for one cycle; go to IDLE.
  - Owner's rdata = m_rdata (pass-through in this cycle) for reads, 0 for writes.
  - The non-owner's ready and rdata are 0.
- Latency from request sampled in IDLE (cycle 0):
  - Read: m_en in cycle 1; ready in cycle 1+MEM_LAT.
  - Write: m_en in cycle 1; d_ready in cycle 2.
  - The next request is sampled in cycle ready+1, so back-to-back accesses have one idle cycle between them.
- A requester that keeps req high after its ready is treated as making a new request.
- Burst counter (saturating):
  - D grant while i_req=1: counter +1.
  - D grant while i_req=0: counter cleared to 0.
  - Any I grant: counter cleared to 0.
- Request changes outside IDLE are ignored. The latched m_* values stay stable from ISSUE through RESP.
- Outside the ISSUE cycle, m_en=0 and m_we=0.
- Simultaneous i_req and d_req in IDLE: D wins unless it is a forced-I case.

Test Plan:
- MEM_LAT=2; i_req=1, i_addr=0x40 in cycle 0 (IDLE) -> m_en=1, m_addr=0x40 in cycle 1; m_rdata=0xDEADBEEF in cycle 3 -> i_ready=1, i_rdata=0xDEADBEEF in cycle 3; busy=0 in cycle 4.
- d_req=1, d_we=1, d_addr=0x54, d_wdata=0x7 -> m_en=m_we=1, m_addr=0x54, m_wdata=0x7 in cycle 1; d_ready=1, d_rdata=0 in cycle 2; i_ready=0 throughout.
- i_req and d_req both asserted in cycle 0 (d_we=0, d_addr=0x80; i_addr=0x10) -> first m_addr=0x80 and d_ready in cycle 3; then m_addr=0x10 in cycle 5 and i_ready in cycle 7.
- d_req and i_req held high continuously, MAX_D_BURST=4 -> grant order D,D,D,D,I,D,D,D,D,I; i_ready occurs exactly once per 5 grants.
- MEM_LAT=1 read -> ready in cycle 2. MEM_LAT=3 read -> ready in cycle 4 with exactly 2 WAIT cycles.
- reset=0 during the WAIT of a read -> next cycle: all outputs 0, busy=0, no ready pulse; a request presented after reset=1 is served normally.
